// File: rtl/dma_axi_slave_mem.sv
// dma_axi_slave_mem: AXI4 responder backed by a local byte-addressable memory.
// Read and write channels run as independent single-burst FSMs supporting
// INCR/FIXED bursts, byte strobes and out-of-window DECERR responses.
// Optional macro DMA_SLV_BP_EN: gates awready/wready/arready with an LFSR bit
// to inject pseudo-random backpressure.

package dma_axi_slave_mem_pkg;
  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;

  typedef logic [AXI_ADDR_W-1:0]   axi_addr_t;
  typedef logic [AXI_DATA_W-1:0]   axi_data_t;
  typedef logic [AXI_DATA_W/8-1:0] axi_strb_t;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef struct packed {
    axi_addr_t  awaddr;
    logic [7:0] awlen;
    logic [2:0] awsize;
    logic [1:0] awburst;
    logic       awvalid;
    axi_data_t  wdata;
    axi_strb_t  wstrb;
    logic       wlast;
    logic       wvalid;
    logic       bready;
    axi_addr_t  araddr;
    logic [7:0] arlen;
    logic [2:0] arsize;
    logic [1:0] arburst;
    logic       arvalid;
    logic       rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic       awready;
    logic       wready;
    logic [1:0] bresp;
    logic       bvalid;
    logic       arready;
    axi_data_t  rdata;
    logic [1:0] rresp;
    logic       rlast;
    logic       rvalid;
  } s_axi_miso_t;
endpackage

module dma_axi_slave_mem
  import dma_axi_slave_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter axi_addr_t   BASE_ADDR = '0,
  parameter logic [15:0] BP_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  s_axi_mosi_t dma_mosi_i,
  output s_axi_miso_t dma_miso_o,
  output logic [15:0] rd_txn_cnt_o,
  output logic [15:0] wr_txn_cnt_o
);

  localparam int unsigned BYTES   = AXI_DATA_W / 8;
  localparam int unsigned OFF_LSB = $clog2(BYTES);
  localparam int unsigned IDX_W   = $clog2(MEM_WORDS);
  localparam logic [AXI_ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [AXI_ADDR_W:0] WIN_HI = WIN_LO + (AXI_ADDR_W + 1)'(MEM_WORDS * BYTES);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  function automatic logic in_window(input axi_addr_t a);
    return ({1'b0, a} >= WIN_LO) && ({1'b0, a} < WIN_HI);
  endfunction

  // Low address bits below the word size are simply dropped (unaligned truncates).
  function automatic logic [IDX_W-1:0] word_idx(input axi_addr_t a);
    axi_addr_t off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> OFF_LSB);
  endfunction

  function automatic axi_addr_t next_addr(input axi_addr_t a, input logic [2:0] size,
                                          input logic [1:0] burst);
    return (burst == AXI_BURST_FIXED) ? a : a + (axi_addr_t'(1) << size);
  endfunction

  function automatic logic [1:0] resolve_resp(input logic dec, input logic slv);
    return dec ? AXI_RESP_DECERR : (slv ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
  endfunction

  axi_data_t mem [MEM_WORDS];

  logic bp_gate;

`ifdef DMA_SLV_BP_EN
  logic [15:0] lfsr;

  // Free-running Fibonacci LFSR (taps 16,14,13,11) that supplies the stall pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= BP_SEED;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign bp_gate = lfsr[0];
`else
  // The seed is required to be nonzero, so without backpressure this is constant 1.
  assign bp_gate = |BP_SEED;
`endif

  // ---------------- write path ----------------
  w_state_t   w_state;
  axi_addr_t  aw_addr;
  logic [7:0] aw_len;
  logic [2:0] aw_size;
  logic [1:0] aw_burst;
  logic [7:0] w_beat;
  logic       w_dec, w_slv;
  logic       awready_q, wready_q, bvalid_q;
  logic [1:0] bresp_q;

  logic awready, wready, aw_hs, w_hs, w_last_beat, w_in_win, w_wrap;
  logic beat_dec, beat_slv, mem_we;
  logic [IDX_W-1:0] w_idx;

  assign awready     = awready_q & bp_gate;
  assign wready      = wready_q & bp_gate;
  assign aw_hs       = dma_mosi_i.awvalid & awready;
  assign w_hs        = dma_mosi_i.wvalid & wready;
  assign w_last_beat = (w_beat == aw_len);
  assign w_in_win    = in_window(aw_addr);
  assign w_wrap      = (aw_burst == AXI_BURST_WRAP);
  assign beat_dec    = ~w_in_win;
  assign beat_slv    = w_wrap | (dma_mosi_i.wlast != w_last_beat);
  assign mem_we      = w_hs & w_in_win & ~w_wrap;
  assign w_idx       = word_idx(aw_addr);

  // Write FSM: accept one AW, count beats to awlen, then hold B until bready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state      <= W_IDLE;
      aw_addr      <= '0;
      aw_len       <= '0;
      aw_size      <= '0;
      aw_burst     <= '0;
      w_beat       <= '0;
      w_dec        <= 1'b0;
      w_slv        <= 1'b0;
      awready_q    <= 1'b0;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= AXI_RESP_OKAY;
      wr_txn_cnt_o <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_addr   <= dma_mosi_i.awaddr;
            aw_len    <= dma_mosi_i.awlen;
            aw_size   <= dma_mosi_i.awsize;
            aw_burst  <= dma_mosi_i.awburst;
            w_beat    <= '0;
            w_dec     <= 1'b0;
            w_slv     <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state   <= W_DATA;
          end else begin
            awready_q <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            aw_addr <= next_addr(aw_addr, aw_size, aw_burst);
            w_beat  <= w_beat + 8'd1;
            w_dec   <= w_dec | beat_dec;
            w_slv   <= w_slv | beat_slv;
            if (w_last_beat) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= resolve_resp(w_dec | beat_dec, w_slv | beat_slv);
              w_state  <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (dma_mosi_i.bready) begin
            bvalid_q     <= 1'b0;
            bresp_q      <= AXI_RESP_OKAY;
            wr_txn_cnt_o <= wr_txn_cnt_o + 16'd1;
            awready_q    <= 1'b1;
            w_state      <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Memory array is not reset; strobed bytes of an accepted in-window beat land here.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < int'(BYTES); b++) begin
        if (dma_mosi_i.wstrb[b]) mem[w_idx][8*b +: 8] <= dma_mosi_i.wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_t   r_state;
  axi_addr_t  ar_addr;
  logic [7:0] ar_len;
  logic [2:0] ar_size;
  logic [1:0] ar_burst;
  logic [7:0] r_beat;
  logic       arready_q, rvalid_q;

  logic       arready, ar_hs, r_hs, r_last_beat;
  axi_data_t  r_data;
  logic [1:0] r_resp;

  assign arready     = arready_q & bp_gate;
  assign ar_hs       = dma_mosi_i.arvalid & arready;
  assign r_hs        = rvalid_q & dma_mosi_i.rready;
  assign r_last_beat = (r_beat == ar_len);

  // Read FSM: accept one AR, then step through beats on each R handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= R_IDLE;
      ar_addr      <= '0;
      ar_len       <= '0;
      ar_size      <= '0;
      ar_burst     <= '0;
      r_beat       <= '0;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rd_txn_cnt_o <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            ar_addr   <= dma_mosi_i.araddr;
            ar_len    <= dma_mosi_i.arlen;
            ar_size   <= dma_mosi_i.arsize;
            ar_burst  <= dma_mosi_i.arburst;
            r_beat    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            r_state   <= R_DATA;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_hs) begin
            if (r_last_beat) begin
              rvalid_q     <= 1'b0;
              arready_q    <= 1'b1;
              rd_txn_cnt_o <= rd_txn_cnt_o + 16'd1;
              r_state      <= R_IDLE;
            end else begin
              ar_addr <= next_addr(ar_addr, ar_size, ar_burst);
              r_beat  <= r_beat + 8'd1;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Combinational read of the current beat; errors force zero data.
  always_comb begin
    r_data = '0;
    r_resp = AXI_RESP_OKAY;
    if (rvalid_q) begin
      if (!in_window(ar_addr))             r_resp = AXI_RESP_DECERR;
      else if (ar_burst == AXI_BURST_WRAP) r_resp = AXI_RESP_SLVERR;
      else                                 r_data = mem[word_idx(ar_addr)];
    end
  end

  // Pack the response bundle; anything not listed stays zero.
  always_comb begin
    dma_miso_o         = '0;
    dma_miso_o.awready = awready;
    dma_miso_o.wready  = wready;
    dma_miso_o.bvalid  = bvalid_q;
    dma_miso_o.bresp   = bresp_q;
    dma_miso_o.arready = arready;
    dma_miso_o.rvalid  = rvalid_q;
    dma_miso_o.rdata   = r_data;
    dma_miso_o.rresp   = r_resp;
    dma_miso_o.rlast   = rvalid_q & r_last_beat;
  end

endmodule

// File: tb/tb_dma_axi_slave_mem.sv
// Testbench for dma_axi_slave_mem: single-beat vector table plus hand-written
// burst, backpressure and mid-burst reset sequences.

module tb_dma_axi_slave_mem;
  import dma_axi_slave_mem_pkg::*;

  localparam int TIMEOUT = 50;

  logic        clk = 1'b0;
  logic        rst;
  s_axi_mosi_t mosi;
  s_axi_miso_t miso;
  logic [15:0] rdCnt, wrCnt;

  int total = 0;
  int bad   = 0;
  logic [15:0] wrExp = '0;
  logic [15:0] rdExp = '0;

  axi_data_t  rdBuf [16];
  logic [1:0] rrBuf [16];
  logic       rlBuf [16];

  typedef struct {
    axi_addr_t  waddr;
    logic [1:0] wburst;
    axi_data_t  wdata;
    axi_strb_t  wstrb;
    logic [1:0] expBresp;
    axi_addr_t  raddr;
    logic [1:0] rburst;
    axi_data_t  expRdata;
    logic [1:0] expRresp;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  dma_axi_slave_mem #(
    .MEM_WORDS(1024),
    .BASE_ADDR(32'h0),
    .BP_SEED  (16'hACE1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dma_mosi_i  (mosi),
    .dma_miso_o  (miso),
    .rd_txn_cnt_o(rdCnt),
    .wr_txn_cnt_o(wrCnt)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic sendAw(input axi_addr_t addr, input logic [7:0] len, input logic [1:0] burst);
    int n;
    mosi.awaddr  = addr;
    mosi.awlen   = len;
    mosi.awsize  = 3'd2;
    mosi.awburst = burst;
    mosi.awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!miso.awready && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("awready_wait", 32'(miso.awready), 32'd1);
    @(posedge clk);
    #1 mosi.awvalid = 1'b0;
  endtask

  task automatic sendW(input axi_data_t data, input axi_strb_t strb, input logic last);
    int n;
    mosi.wdata  = data;
    mosi.wstrb  = strb;
    mosi.wlast  = last;
    mosi.wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!miso.wready && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wready_wait", 32'(miso.wready), 32'd1);
    @(posedge clk);
    #1 mosi.wvalid = 1'b0;
  endtask

  task automatic takeB(output logic [1:0] resp);
    int n;
    mosi.bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!miso.bvalid && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bvalid_wait", 32'(miso.bvalid), 32'd1);
    resp = miso.bresp;
    @(posedge clk);
    #1 mosi.bready = 1'b0;
    wrExp = wrExp + 16'd1;
  endtask

  task automatic sendAr(input axi_addr_t addr, input logic [7:0] len, input logic [1:0] burst);
    int n;
    mosi.araddr  = addr;
    mosi.arlen   = len;
    mosi.arsize  = 3'd2;
    mosi.arburst = burst;
    mosi.arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!miso.arready && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("arready_wait", 32'(miso.arready), 32'd1);
    @(posedge clk);
    #1 mosi.arvalid = 1'b0;
  endtask

  task automatic readBurst(input axi_addr_t addr, input logic [7:0] len, input logic [1:0] burst);
    int n;
    sendAr(addr, len, burst);
    mosi.rready = 1'b1;
    for (int k = 0; k <= int'(len); k++) begin
      n = 0;
      @(negedge clk);
      while (!miso.rvalid && n < TIMEOUT) begin
        @(negedge clk);
        n++;
      end
      checkOutput("rvalid_wait", 32'(miso.rvalid), 32'd1);
      rdBuf[k] = miso.rdata;
      rrBuf[k] = miso.rresp;
      rlBuf[k] = miso.rlast;
      @(posedge clk);
      #1;
    end
    mosi.rready = 1'b0;
    rdExp = rdExp + 16'd1;
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    logic [1:0] resp;
    sendAw(v.waddr, 8'd0, v.wburst);
    sendW(v.wdata, v.wstrb, 1'b1);
    takeB(resp);
    checkOutput($sformatf("v%0d_bresp", idx), 32'(resp), 32'(v.expBresp));
    readBurst(v.raddr, 8'd0, v.rburst);
    checkOutput($sformatf("v%0d_rdata", idx), rdBuf[0], v.expRdata);
    checkOutput($sformatf("v%0d_rresp", idx), 32'(rrBuf[0]), 32'(v.expRresp));
    checkOutput($sformatf("v%0d_rlast", idx), 32'(rlBuf[0]), 32'd1);
  endtask

  initial begin
    logic [1:0] resp;
    int k;
    int cyc;

    vecs[0] = '{32'h0000, AXI_BURST_INCR, 32'hCAFEF00D, 4'hF, AXI_RESP_OKAY,   32'h0000, AXI_BURST_INCR, 32'hCAFEF00D, AXI_RESP_OKAY};
    vecs[1] = '{32'h1000, AXI_BURST_INCR, 32'hDEADBEEF, 4'hF, AXI_RESP_DECERR, 32'h0000, AXI_BURST_INCR, 32'hCAFEF00D, AXI_RESP_OKAY};
    vecs[2] = '{32'h0004, AXI_BURST_INCR, 32'h55667788, 4'hF, AXI_RESP_OKAY,   32'h1000, AXI_BURST_INCR, 32'h00000000, AXI_RESP_DECERR};
    vecs[3] = '{32'h0006, AXI_BURST_INCR, 32'hAABBCCDD, 4'hA, AXI_RESP_OKAY,   32'h0004, AXI_BURST_INCR, 32'hAA66CC88, AXI_RESP_OKAY};
    vecs[4] = '{32'h0004, AXI_BURST_WRAP, 32'h00000000, 4'hF, AXI_RESP_SLVERR, 32'h0004, AXI_BURST_INCR, 32'hAA66CC88, AXI_RESP_OKAY};
    vecs[5] = '{32'h0008, AXI_BURST_INCR, 32'h12345678, 4'hF, AXI_RESP_OKAY,   32'h0008, AXI_BURST_WRAP, 32'h00000000, AXI_RESP_SLVERR};
    vecs[6] = '{32'h0FFC, AXI_BURST_INCR, 32'h0BADCAFE, 4'hF, AXI_RESP_OKAY,   32'h0FFC, AXI_BURST_INCR, 32'h0BADCAFE, AXI_RESP_OKAY};
    vecs[7] = '{32'h0008, AXI_BURST_INCR, 32'hFFFFFFFF, 4'h0, AXI_RESP_OKAY,   32'h0008, AXI_BURST_INCR, 32'h12345678, AXI_RESP_OKAY};
    vecs[8] = '{32'h0FFF, AXI_BURST_INCR, 32'h11000000, 4'h8, AXI_RESP_OKAY,   32'h0FFC, AXI_BURST_INCR, 32'h11ADCAFE, AXI_RESP_OKAY};

    mosi = '0;
    rst  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_awready", 32'(miso.awready), 32'd0);
    checkOutput("rst_arready", 32'(miso.arready), 32'd0);
    checkOutput("rst_wready",  32'(miso.wready),  32'd0);
    checkOutput("rst_bvalid",  32'(miso.bvalid),  32'd0);
    checkOutput("rst_rvalid",  32'(miso.rvalid),  32'd0);
    checkOutput("rst_rlast",   32'(miso.rlast),   32'd0);
    checkOutput("rst_rdata",   miso.rdata,        32'd0);
    checkOutput("rst_wrcnt",   32'(wrCnt),        32'd0);
    checkOutput("rst_rdcnt",   32'(rdCnt),        32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("release_awready", 32'(miso.awready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("post_rst_awready", 32'(miso.awready), 32'd1);
    checkOutput("post_rst_arready", 32'(miso.arready), 32'd1);

    $display("[TB] INCR write/read burst");
    sendAw(32'h10, 8'd3, AXI_BURST_INCR);
    checkOutput("wready_after_aw", 32'(miso.wready), 32'd1);
    for (int i = 0; i < 4; i++) sendW(32'hA0 + 32'(i), 4'hF, i == 3);
    checkOutput("bvalid_after_last", 32'(miso.bvalid), 32'd1);
    takeB(resp);
    checkOutput("incr_bresp", 32'(resp), 32'(AXI_RESP_OKAY));
    checkOutput("incr_wrcnt", 32'(wrCnt), 32'(wrExp));
    readBurst(32'h10, 8'd3, AXI_BURST_INCR);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("incr_rdata%0d", i), rdBuf[i], 32'hA0 + 32'(i));
      checkOutput($sformatf("incr_rlast%0d", i), 32'(rlBuf[i]), (i == 3) ? 32'd1 : 32'd0);
      checkOutput($sformatf("incr_rresp%0d", i), 32'(rrBuf[i]), 32'(AXI_RESP_OKAY));
    end
    checkOutput("incr_rdcnt", 32'(rdCnt), 32'(rdExp));

    $display("[TB] FIXED write with strobes");
    sendAw(32'h20, 8'd1, AXI_BURST_FIXED);
    sendW(32'h11223344, 4'hF, 1'b0);
    sendW(32'h000000FF, 4'h1, 1'b1);
    takeB(resp);
    checkOutput("fixed_bresp", 32'(resp), 32'(AXI_RESP_OKAY));
    readBurst(32'h20, 8'd0, AXI_BURST_INCR);
    checkOutput("fixed_rdata", rdBuf[0], 32'h112233FF);

    $display("[TB] vector table");
    for (int i = 0; i < 9; i++) applyStimulus(i, vecs[i]);
    checkOutput("table_wrcnt", 32'(wrCnt), 32'(wrExp));
    checkOutput("table_rdcnt", 32'(rdCnt), 32'(rdExp));

    $display("[TB] early wlast");
    sendAw(32'h40, 8'd3, AXI_BURST_INCR);
    for (int i = 0; i < 4; i++) begin
      sendW(32'hB0 + 32'(i), 4'hF, i == 1);
      if (i < 3) begin
        checkOutput($sformatf("early_bvalid%0d", i), 32'(miso.bvalid), 32'd0);
        checkOutput($sformatf("early_wready%0d", i), 32'(miso.wready), 32'd1);
      end
    end
    checkOutput("early_bvalid_end", 32'(miso.bvalid), 32'd1);
    takeB(resp);
    checkOutput("early_bresp", 32'(resp), 32'(AXI_RESP_SLVERR));
    readBurst(32'h40, 8'd3, AXI_BURST_INCR);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("early_rdata%0d", i), rdBuf[i], 32'hB0 + 32'(i));

    $display("[TB] B backpressure");
    sendAw(32'h2000, 8'd0, AXI_BURST_INCR);
    sendW(32'h77, 4'hF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bhold_bvalid%0d", i), 32'(miso.bvalid), 32'd1);
      checkOutput($sformatf("bhold_bresp%0d", i), 32'(miso.bresp), 32'(AXI_RESP_DECERR));
    end
    @(posedge clk);
    #1;
    takeB(resp);
    checkOutput("bhold_bresp_final", 32'(resp), 32'(AXI_RESP_DECERR));
    checkOutput("bhold_wrcnt", 32'(wrCnt), 32'(wrExp));

    $display("[TB] R backpressure");
    sendAw(32'h50, 8'd3, AXI_BURST_INCR);
    for (int i = 0; i < 4; i++) sendW(32'hC0 + 32'(i), 4'hF, i == 3);
    takeB(resp);
    checkOutput("rbp_bresp", 32'(resp), 32'(AXI_RESP_OKAY));
    sendAr(32'h50, 8'd3, AXI_BURST_INCR);
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 40) begin
      mosi.rready = (cyc % 2) == 1;
      @(negedge clk);
      if (miso.rvalid) begin
        checkOutput($sformatf("rbp_rdata_c%0d", cyc), miso.rdata, 32'hC0 + 32'(k));
        checkOutput($sformatf("rbp_rlast_c%0d", cyc), 32'(miso.rlast), (k == 3) ? 32'd1 : 32'd0);
        if (mosi.rready) k++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    mosi.rready = 1'b0;
    rdExp = rdExp + 16'd1;
    checkOutput("rbp_beats", 32'(k), 32'd4);
    checkOutput("rbp_rvalid_end", 32'(miso.rvalid), 32'd0);
    checkOutput("rbp_rdcnt", 32'(rdCnt), 32'(rdExp));

    $display("[TB] reset during read");
    sendAr(32'h50, 8'd3, AXI_BURST_INCR);
    mosi.rready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rstrd_rdata%0d", i), miso.rdata, 32'hC0 + 32'(i));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    checkOutput("rstrd_beat2", miso.rdata, 32'hC2);
    #1 rst = 1'b1;
    #1;
    checkOutput("rstrd_rvalid", 32'(miso.rvalid), 32'd0);
    checkOutput("rstrd_arready", 32'(miso.arready), 32'd0);
    checkOutput("rstrd_rdcnt", 32'(rdCnt), 32'd0);
    checkOutput("rstrd_wrcnt", 32'(wrCnt), 32'd0);
    mosi.rready = 1'b0;
    wrExp = '0;
    rdExp = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("rstrd_release_arready", 32'(miso.arready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rstrd_after_arready", 32'(miso.arready), 32'd1);
    readBurst(32'h50, 8'd3, AXI_BURST_INCR);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("rstrd_reread%0d", i), rdBuf[i], 32'hC0 + 32'(i));
    checkOutput("rstrd_final_rdcnt", 32'(rdCnt), 32'(rdExp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
